if_pc_queue: RTL

IF_PC_QUEUE -- requirements
Module: if_pc_queue

---
 rtl/if_pc_queue_pkg.sv | 16 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/if_pc_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/if_pc_queue_pkg.sv
// Shared fetch-path constants for the PC/instruction pairing queue.
package if_pc_queue_pkg;

  localparam int unsigned InstAddrWidth = 32;
  localparam int unsigned FetchWidth    = 64;

  localparam logic [InstAddrWidth-1:0] ZeroWord = '0;
  localparam logic InstValid   = 1'b1;
  localparam logic InstInvalid = 1'b0;

  // Occupancy counters must be able to represent DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with synchronous clear; the head entry is visible on dout.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_pc_queue.sv
// Pairs in-order icache responses with the PCs that requested them, dropping
// responses that belong to fetches killed by a flush or taken branch.
module if_pc_queue
  import if_pc_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = InstAddrWidth,
  parameter int unsigned INST_WIDTH = FetchWidth,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   branch_flag_i,
  input  logic                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  req_pc_i,
  output logic                   req_ready_o,
  input  logic                   rsp_valid_i,
  input  logic [INST_WIDTH-1:0]  rsp_inst_i,
  output logic                   rsp_ready_o,
  output logic                   out_valid_o,
  output logic [ADDR_WIDTH-1:0]  out_pc_o,
  output logic [INST_WIDTH-1:0]  out_inst_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic                  kill;
  logic                  enq;
  logic                  deq;
  logic                  dropping;
  logic                  load;
  logic [CW-1:0]         count;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         drop_nxt;
  logic [CW:0]           occupancy;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  full;
  logic                  empty;

  assign kill      = flush_i | branch_flag_i;
  assign dropping  = (drop_cnt != '0);
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt};

  // Icache slots are shared by live fetches and killed ones still in flight.
  assign req_ready_o = rst & ~full & (occupancy < (CW+1)'(DEPTH)) & ~kill;
  assign rsp_ready_o = dropping | (~empty & (~out_valid_o | out_ready_i));

  assign enq     = req_valid_i & req_ready_o;
  assign deq     = rsp_valid_i & rsp_ready_o;
  assign load    = deq & ~dropping & ~kill;
  assign count_o = count;

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (kill),
    .push  (enq),
    .pop   (deq & ~dropping),
    .din   (req_pc_i),
    .dout  (head_pc),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // On kill, every response still owed after this cycle becomes a drop.
  always_comb begin
    drop_nxt = drop_cnt;
    if (kill) begin
      drop_nxt = CW'(occupancy - (CW+1)'(deq));
    end else if (deq && dropping) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
    end
  end

  // Output stage: holds while decode stalls, zeroed on kill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= InstInvalid;
      out_pc_o    <= ADDR_WIDTH'(ZeroWord);
      out_inst_o  <= '0;
    end else if (kill) begin
      out_valid_o <= InstInvalid;
      out_pc_o    <= ADDR_WIDTH'(ZeroWord);
      out_inst_o  <= '0;
    end else if (load) begin
      out_valid_o <= InstValid;
      out_pc_o    <= head_pc;
      out_inst_o  <= rsp_inst_i;
    end else if (out_ready_i) begin
      out_valid_o <= InstInvalid;
    end
  end

endmodule
